game_sprite_control: RTL and testbench

GAME_SPRITE_CONTROL -- requirements
Module: game_sprite_control

---
 rtl/game_pkg.sv | 10 +
 rtl/game_sprite_pixel_hit.sv | 48 ++++
 rtl/game_sprite_control.sv | 102 ++++++++++
 tb/tb_game_sprite_control.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared display geometry and colour widths for the game blocks.
package game_pkg;

  localparam int unsigned SCREEN_WIDTH  = 640;
  localparam int unsigned SCREEN_HEIGHT = 480;
  localparam int unsigned X_WIDTH       = 10;
  localparam int unsigned Y_WIDTH       = 10;
  localparam int unsigned RGB_WIDTH     = 3;

endpackage

// File: rtl/game_sprite_pixel_hit.sv
// Registered sprite/pixel coincidence test and colour output.
module game_sprite_pixel_hit
  import game_pkg::*;
#(
  parameter int unsigned          SPRITE_WIDTH  = 8,
  parameter int unsigned          SPRITE_HEIGHT = 8,
  parameter logic [RGB_WIDTH-1:0] SPRITE_RGB    = 3'b111
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [X_WIDTH-1:0]   pixel_x,
  input  logic [Y_WIDTH-1:0]   pixel_y,
  input  logic [X_WIDTH-1:0]   sprite_x,
  input  logic [Y_WIDTH-1:0]   sprite_y,
  output logic                 rgb_en,
  output logic [RGB_WIDTH-1:0] rgb
);

  // One extra bit so the far edge of a sprite near the wrap point does not alias to 0.
  logic [X_WIDTH:0] px_ext, x_lo, x_hi;
  logic [Y_WIDTH:0] py_ext, y_lo, y_hi;
  logic             hit;
  logic             rgb_en_q;

  // Bounding-box comparison on the extended coordinates.
  always_comb begin
    px_ext = {1'b0, pixel_x};
    py_ext = {1'b0, pixel_y};
    x_lo   = {1'b0, sprite_x};
    y_lo   = {1'b0, sprite_y};
    x_hi   = x_lo + (X_WIDTH + 1)'(SPRITE_WIDTH);
    y_hi   = y_lo + (Y_WIDTH + 1)'(SPRITE_HEIGHT);
    hit    = (px_ext >= x_lo) && (px_ext < x_hi) && (py_ext >= y_lo) && (py_ext < y_hi);
  end

  // Register the hit so rgb_en lags pixel_x/y by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_en_q <= 1'b0;
    end else begin
      rgb_en_q <= hit;
    end
  end

  assign rgb_en = rgb_en_q;
  assign rgb    = rgb_en_q ? SPRITE_RGB : '0;

endmodule

// File: rtl/game_sprite_control.sv
// Sprite position/velocity registers, motion tick divider and on-screen flag.
module game_sprite_control
  import game_pkg::*;
#(
  parameter int unsigned          SPRITE_WIDTH     = 8,
  parameter int unsigned          SPRITE_HEIGHT    = 8,
  parameter int unsigned          DX_WIDTH         = 4,
  parameter int unsigned          DY_WIDTH         = 4,
  parameter int unsigned          UPDATE_DIV_WIDTH = 16,
  parameter logic [RGB_WIDTH-1:0] SPRITE_RGB       = 3'b111
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [X_WIDTH-1:0]         pixel_x,
  input  logic [Y_WIDTH-1:0]         pixel_y,
  input  logic                       sprite_write_xy,
  input  logic                       sprite_write_dxy,
  input  logic                       sprite_enable_update,
  input  logic [X_WIDTH-1:0]         sprite_write_x,
  input  logic [Y_WIDTH-1:0]         sprite_write_y,
  input  logic signed [DX_WIDTH-1:0] sprite_write_dx,
  input  logic signed [DY_WIDTH-1:0] sprite_write_dy,
  output logic [X_WIDTH-1:0]         sprite_x,
  output logic [Y_WIDTH-1:0]         sprite_y,
  output logic                       sprite_within_screen,
  output logic                       rgb_en,
  output logic [RGB_WIDTH-1:0]       rgb
);

  logic [UPDATE_DIV_WIDTH-1:0] div_q;
  logic [X_WIDTH-1:0]          x_q, x_d;
  logic [Y_WIDTH-1:0]          y_q, y_d;
  logic signed [DX_WIDTH-1:0]  dx_q, dx_d;
  logic signed [DY_WIDTH-1:0]  dy_q, dy_d;
  logic                        within_q;
  logic                        tick;
  logic [X_WIDTH-1:0]          dx_ext;
  logic [Y_WIDTH-1:0]          dy_ext;

  assign tick   = (div_q == '1) && sprite_enable_update;
  // Signed casts sign-extend the velocities to the position width.
  assign dx_ext = X_WIDTH'(dx_q);
  assign dy_ext = Y_WIDTH'(dy_q);

  // Next position/velocity: a position load beats a tick; a tick always uses the current velocity.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (sprite_write_xy) begin
      x_d = sprite_write_x;
      y_d = sprite_write_y;
    end else if (tick) begin
      x_d = x_q + dx_ext;
      y_d = y_q + dy_ext;
    end
    if (sprite_write_dxy) begin
      dx_d = sprite_write_dx;
      dy_d = sprite_write_dy;
    end
  end

  // State registers; the on-screen flag is computed from the already-registered position.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      within_q <= 1'b1;
    end else begin
      div_q    <= div_q + UPDATE_DIV_WIDTH'(1);
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      within_q <= (x_q < X_WIDTH'(SCREEN_WIDTH)) && (y_q < Y_WIDTH'(SCREEN_HEIGHT));
    end
  end

  assign sprite_x             = x_q;
  assign sprite_y             = y_q;
  assign sprite_within_screen = within_q;

  game_sprite_pixel_hit #(
    .SPRITE_WIDTH  (SPRITE_WIDTH),
    .SPRITE_HEIGHT (SPRITE_HEIGHT),
    .SPRITE_RGB    (SPRITE_RGB)
  ) u_pixel_hit (
    .clk      (clk),
    .rst      (rst),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .sprite_x (x_q),
    .sprite_y (y_q),
    .rgb_en   (rgb_en),
    .rgb      (rgb)
  );

endmodule

// File: tb/tb_game_sprite_control.sv
// Directed bench for game_sprite_control with a 2-bit motion divider.
module tb_game_sprite_control;

  logic              clk;
  logic              rst;
  logic [9:0]        pixel_x, pixel_y;
  logic              sprite_write_xy, sprite_write_dxy, sprite_enable_update;
  logic [9:0]        sprite_write_x, sprite_write_y;
  logic signed [3:0] sprite_write_dx, sprite_write_dy;
  logic [9:0]        sprite_x, sprite_y;
  logic              sprite_within_screen;
  logic              rgb_en;
  logic [2:0]        rgb;

  int checks = 0;
  int errors = 0;
  int div_m  = 0;

  game_sprite_control #(
    .UPDATE_DIV_WIDTH (2)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .pixel_x              (pixel_x),
    .pixel_y              (pixel_y),
    .sprite_write_xy      (sprite_write_xy),
    .sprite_write_dxy     (sprite_write_dxy),
    .sprite_enable_update (sprite_enable_update),
    .sprite_write_x       (sprite_write_x),
    .sprite_write_y       (sprite_write_y),
    .sprite_write_dx      (sprite_write_dx),
    .sprite_write_dy      (sprite_write_dy),
    .sprite_x             (sprite_x),
    .sprite_y             (sprite_y),
    .sprite_within_screen (sprite_within_screen),
    .rgb_en               (rgb_en),
    .rgb                  (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; afterwards outputs are sampled 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) div_m = 0;
    else div_m = (div_m + 1) % 4;
  endtask

  // Advance until n motion ticks have been applied (enable must be high).
  task automatic run_ticks(input int n);
    int t = 0;
    while (t < n) begin
      if (div_m == 3) t++;
      step();
    end
  endtask

  // Advance with no tick until the next edge would be a tick edge.
  task automatic to_tick_edge();
    while (div_m != 3) step();
  endtask

  task automatic load_xy(input int x, input int y);
    sprite_write_xy = 1'b1;
    sprite_write_x  = 10'(x);
    sprite_write_y  = 10'(y);
    step();
    sprite_write_xy = 1'b0;
  endtask

  task automatic load_dxy(input int dx, input int dy);
    sprite_write_dxy = 1'b1;
    sprite_write_dx  = 4'(dx);
    sprite_write_dy  = 4'(dy);
    step();
    sprite_write_dxy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pixel_x = '0;
    pixel_y = '0;
    sprite_write_xy = 1'b0;
    sprite_write_dxy = 1'b0;
    sprite_enable_update = 1'b0;
    sprite_write_x = '0;
    sprite_write_y = '0;
    sprite_write_dx = '0;
    sprite_write_dy = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_x", 32'(sprite_x), 0);
    check("reset_y", 32'(sprite_y), 0);
    check("reset_within", 32'(sprite_within_screen), 1);
    check("reset_rgb_en", 32'(rgb_en), 0);
    check("reset_rgb", 32'(rgb), 0);

    // Basic motion: three ticks of (+2,-1) from (100,50).
    load_xy(100, 50);
    load_dxy(2, -1);
    sprite_enable_update = 1'b1;
    run_ticks(3);
    sprite_enable_update = 1'b0;
    check("motion_x", 32'(sprite_x), 106);
    check("motion_y", 32'(sprite_y), 47);
    step();
    check("motion_within", 32'(sprite_within_screen), 1);
    step();
    step();
    step();
    step();
    check("hold_x", 32'(sprite_x), 106);

    // Negative wrap reads as off-screen one cycle later.
    load_xy(1, 10);
    load_dxy(-2, 0);
    sprite_enable_update = 1'b1;
    run_ticks(1);
    sprite_enable_update = 1'b0;
    check("wrap_x", 32'(sprite_x), 1023);
    check("wrap_y", 32'(sprite_y), 10);
    step();
    check("wrap_within", 32'(sprite_within_screen), 0);

    // Position load beats a coincident tick.
    load_dxy(3, 0);
    sprite_enable_update = 1'b1;
    to_tick_edge();
    sprite_write_xy = 1'b1;
    sprite_write_x  = 10'd200;
    sprite_write_y  = 10'd200;
    step();
    sprite_write_xy = 1'b0;
    sprite_enable_update = 1'b0;
    check("xy_over_tick_x", 32'(sprite_x), 200);
    check("xy_over_tick_y", 32'(sprite_y), 200);

    // Velocity load coincident with a tick: tick uses the old velocity.
    load_xy(10, 10);
    load_dxy(1, 0);
    sprite_enable_update = 1'b1;
    to_tick_edge();
    sprite_write_dxy = 1'b1;
    sprite_write_dx  = 4'sd5;
    sprite_write_dy  = 4'sd0;
    step();
    sprite_write_dxy = 1'b0;
    check("dxy_tick_old_x", 32'(sprite_x), 11);
    run_ticks(1);
    sprite_enable_update = 1'b0;
    check("dxy_tick_new_x", 32'(sprite_x), 16);

    // Pixel hit boundaries.
    load_xy(20, 30);
    pixel_x = 10'd27; pixel_y = 10'd37;
    step();
    check("hit_27_37_en", 32'(rgb_en), 1);
    check("hit_27_37_rgb", 32'(rgb), 7);
    pixel_x = 10'd28; pixel_y = 10'd37;
    step();
    check("miss_28_37_en", 32'(rgb_en), 0);
    check("miss_28_37_rgb", 32'(rgb), 0);
    pixel_x = 10'd20; pixel_y = 10'd30;
    step();
    check("hit_20_30_en", 32'(rgb_en), 1);
    pixel_x = 10'd19; pixel_y = 10'd30;
    step();
    check("miss_19_30_en", 32'(rgb_en), 0);
    pixel_x = 10'd27; pixel_y = 10'd38;
    step();
    check("miss_27_38_en", 32'(rgb_en), 0);
    load_xy(1020, 0);
    pixel_x = 10'd3; pixel_y = 10'd0;
    step();
    check("no_wrap_hit_en", 32'(rgb_en), 0);
    pixel_x = 10'd1023; pixel_y = 10'd7;
    step();
    check("edge_hit_en", 32'(rgb_en), 1);

    // Reset during motion with strobes high.
    load_xy(700, 5);
    load_dxy(1, 1);
    sprite_enable_update = 1'b1;
    run_ticks(1);
    step();
    check("pre_rst_within", 32'(sprite_within_screen), 0);
    rst = 1'b1;
    sprite_write_xy = 1'b1;
    sprite_write_dxy = 1'b1;
    sprite_write_x = 10'd300;
    sprite_write_y = 10'd300;
    sprite_write_dx = 4'sd2;
    sprite_write_dy = 4'sd2;
    step();
    rst = 1'b0;
    sprite_write_xy = 1'b0;
    sprite_write_dxy = 1'b0;
    sprite_enable_update = 1'b0;
    check("rst_x", 32'(sprite_x), 0);
    check("rst_y", 32'(sprite_y), 0);
    check("rst_within", 32'(sprite_within_screen), 1);
    check("rst_rgb_en", 32'(rgb_en), 0);
    // Divider restarts at 0: a load of dx=+1 then the first tick lands three edges later.
    load_dxy(1, 0);
    sprite_enable_update = 1'b1;
    step();
    step();
    check("rst_div_pre_tick_x", 32'(sprite_x), 0);
    step();
    check("rst_div_tick_x", 32'(sprite_x), 1);
    sprite_enable_update = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
